// File: rtl/arbiter_param.sv
// N-way request/grant arbiter with a registered one-hot grant.
// MODE=0 is fixed priority (index 0 wins); MODE=1 is round-robin with a MAX_HOLD fairness limit.
module arbiter_param #(
  parameter int N        = 4,
  parameter int MODE     = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        r_state, w_stateNext;
  logic [IW-1:0] r_ptr, w_ptrNext;
  logic [IW-1:0] r_gntId, w_gntIdNext;
  logic [IW-1:0] w_nextOwner;
  logic [HW-1:0] r_holdCnt, w_holdNext;
  logic [N-1:0]  r_gnt, w_gntNext;
  logic [N-1:0]  w_others;
  logic          r_valid, w_validNext;

  // First set request bit scanning upward from start, wrapping modulo N.
  function automatic logic [IW-1:0] pick(input logic [N-1:0] r, input logic [IW-1:0] start);
    logic [IW-1:0] idx;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(start) + k) % N);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign w_nextOwner = (r_gntId == IW'(N - 1)) ? '0 : r_gntId + IW'(1);
  assign w_others    = req & ~(N'(1) << r_gntId);

  always_comb begin
    w_stateNext = r_state;
    w_ptrNext   = r_ptr;
    w_holdNext  = r_holdCnt;
    w_gntIdNext = r_gntId;
    w_validNext = r_valid;

    if (MODE == 0) begin
      w_stateNext = IDLE;
      w_ptrNext   = '0;
      w_holdNext  = '0;
      w_validNext = |req;
      w_gntIdNext = pick(req, '0);
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            w_gntIdNext = pick(req, r_ptr);
            w_validNext = 1'b1;
            w_holdNext  = '0;
            w_stateNext = GRANT;
          end else begin
            w_gntIdNext = '0;
            w_validNext = 1'b0;
          end
        end
        GRANT: begin
          if (!req[r_gntId]) begin
            // Owner released: hand over on the same edge so there is no idle bubble.
            w_ptrNext = w_nextOwner;
            if (|req) begin
              w_gntIdNext = pick(req, w_nextOwner);
              w_holdNext  = '0;
            end else begin
              w_gntIdNext = '0;
              w_validNext = 1'b0;
              w_stateNext = IDLE;
            end
          end else if (r_holdCnt < HOLD_LAST) begin
            w_holdNext = r_holdCnt + HW'(1);
          end else if (|w_others) begin
            w_gntIdNext = pick(req, w_nextOwner);
            w_holdNext  = '0;
            w_ptrNext   = w_nextOwner;
          end else begin
            w_holdNext = '0;
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end

    w_gntNext = w_validNext ? (N'(1) << w_gntIdNext) : '0;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_holdCnt <= '0;
      r_gntId   <= '0;
      r_valid   <= 1'b0;
      r_gnt     <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_ptr     <= w_ptrNext;
      r_holdCnt <= w_holdNext;
      r_gntId   <= w_gntIdNext;
      r_valid   <= w_validNext;
      r_gnt     <= w_gntNext;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_valid;
  assign gnt_id    = r_gntId;

endmodule

// File: tb/tb_arbiter_param.sv
// Directed scoreboard bench for arbiter_param: one fixed-priority and one round-robin
// instance (N=4, MAX_HOLD=4) driven side by side, plus per-cycle grant invariants.
module tb_arbiter_param;

  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic [3:0] req0, req1;
  logic [3:0] gnt0, gnt1;
  logic       valid0, valid1;
  logic [1:0] id0, id1;
  logic [3:0] prevReq0, prevReq1;
  logic       running = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] g0;
    logic [3:0] g1;
  } exp_t;

  exp_t expQ[$];

  always #5 clk = ~clk;

  arbiter_param #(.N(4), .MODE(0), .MAX_HOLD(4)) u_fixed (
    .clk(clk), .rstn(rst0), .req(req0),
    .gnt(gnt0), .gnt_valid(valid0), .gnt_id(id0)
  );

  arbiter_param #(.N(4), .MODE(1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .rstn(rst1), .req(req1),
    .gnt(gnt1), .gnt_valid(valid1), .gnt_id(id1)
  );

  function automatic logic [1:0] idOf(input logic [3:0] g);
    idOf = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (g[i]) idOf = 2'(i);
  endfunction

  task automatic checkValue(input string tag, input string what,
                            input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s %s: observed %b expected %b", tag, what, obs, exp);
    end
  endtask

  task automatic checkInvariants(input string tag, input logic [3:0] g, input logic v,
                                 input logic [1:0] id, input logic [3:0] p);
    checkValue(tag, "onehot0", {3'b0, $onehot0(g)}, 4'd1);
    checkValue(tag, "valid_is_or", {3'b0, v}, {3'b0, |g});
    checkValue(tag, "id_matches_gnt", {2'b0, id}, {2'b0, idOf(g)});
    checkValue(tag, "gnt_within_req", g & ~p, 4'b0000);
  endtask

  // Per-cycle invariants against the request seen at the sampling edge.
  always @(posedge clk) begin
    prevReq0 = req0;
    prevReq1 = req1;
    #1;
    if (running) begin
      checkInvariants("inv_fixed", gnt0, valid0, id0, prevReq0);
      checkInvariants("inv_rr", gnt1, valid1, id1, prevReq1);
    end
  end

  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (expQ.size() != 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
    end
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      checkValue({e.tag, "_fixed"}, "gnt", gnt0, e.g0);
      checkValue({e.tag, "_fixed"}, "gnt_valid", {3'b0, valid0}, {3'b0, |e.g0});
      checkValue({e.tag, "_fixed"}, "gnt_id", {2'b0, id0}, {2'b0, idOf(e.g0)});
      checkValue({e.tag, "_rr"}, "gnt", gnt1, e.g1);
      checkValue({e.tag, "_rr"}, "gnt_valid", {3'b0, valid1}, {3'b0, |e.g1});
      checkValue({e.tag, "_rr"}, "gnt_id", {2'b0, id1}, {2'b0, idOf(e.g1)});
    end
  endtask

  task automatic applyStimulus(input string tag,
                               input logic r0, input logic [3:0] q0, input logic [3:0] e0,
                               input logic r1, input logic [3:0] q1, input logic [3:0] e1);
    exp_t e;
    @(negedge clk);
    rst0 = r0;
    req0 = q0;
    rst1 = r1;
    req1 = q1;
    e.tag = tag;
    e.g0  = e0;
    e.g1  = e1;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    rst0    = 1'b1;
    rst1    = 1'b1;
    req0    = 4'b0000;
    req1    = 4'b0000;
    running = 1'b1;

    // Reset dominates a full request vector.
    applyStimulus("reset", 1, 4'b1111, 4'b0000, 1, 4'b1111, 4'b0000);
    applyStimulus("reset", 1, 4'b1111, 4'b0000, 1, 4'b1111, 4'b0000);

    // Fixed priority, round-robin instance parked in reset.
    applyStimulus("fp_lowest", 0, 4'b0110, 4'b0010, 1, 4'b0000, 4'b0000);
    applyStimulus("fp_preempt", 0, 4'b1111, 4'b0001, 1, 4'b0000, 4'b0000);
    applyStimulus("fp_none", 0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000);
    applyStimulus("fp_top", 0, 4'b1000, 4'b1000, 1, 4'b0000, 4'b0000);
    applyStimulus("fp_pair", 0, 4'b1100, 4'b0100, 1, 4'b0000, 4'b0000);
    applyStimulus("fp_split", 0, 4'b0101, 4'b0001, 1, 4'b0000, 4'b0000);

    // Round-robin fairness: each owner holds exactly MAX_HOLD cycles, then wraps to 0.
    for (int g = 0; g < 4; g++)
      for (int k = 0; k < 4; k++)
        applyStimulus("rr_fair", 0, 4'b0000, 4'b0000, 0, 4'b1111, 4'(1 << g));
    applyStimulus("rr_wrap", 0, 4'b0000, 4'b0000, 0, 4'b1111, 4'b0001);

    // Owner 0 drops while 1 and 3 request: immediate handover to 1.
    applyStimulus("rr_release", 0, 4'b0000, 4'b0000, 0, 4'b1010, 4'b0010);
    for (int k = 0; k < 3; k++)
      applyStimulus("rr_hold1", 0, 4'b0000, 4'b0000, 0, 4'b1010, 4'b0010);
    applyStimulus("rr_force3", 0, 4'b0000, 4'b0000, 0, 4'b1010, 4'b1000);
    applyStimulus("rr_hold3", 0, 4'b0000, 4'b0000, 0, 4'b1010, 4'b1000);
    applyStimulus("rr_wrap_rel", 0, 4'b0000, 4'b0000, 0, 4'b0010, 4'b0010);
    applyStimulus("rr_idle", 0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000);

    // Sole requester keeps the grant through the hold limit without gaps.
    for (int k = 0; k < 10; k++)
      applyStimulus("rr_sole", 0, 4'b0000, 4'b0000, 0, 4'b0100, 4'b0100);

    // Reset mid-grant, then restart from requester 0.
    applyStimulus("rr_rst_mid", 0, 4'b0000, 4'b0000, 1, 4'b0100, 4'b0000);
    applyStimulus("rr_restart", 0, 4'b0000, 4'b0000, 0, 4'b1111, 4'b0001);
    applyStimulus("rr_drop", 0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000);
    applyStimulus("rr_ptr_wrap", 0, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0001);

    running = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
